// File: rtl/product_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package product_bcd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam int ADD3_THRESH = 5;

    // Number of decimal digits needed to show 2^in_w - 1.
    function automatic int digits_needed(input int in_w);
        longint unsigned max_v;
        int              d;
        max_v = (64'd1 << in_w) - 64'd1;
        d     = 1;
        max_v = max_v / 64'd10;
        while (max_v != 64'd0) begin
            d     = d + 1;
            max_v = max_v / 64'd10;
        end
        return d;
    endfunction

endpackage

// File: rtl/product_bcd_seq_bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 when the digit is 5 or more.
// Latency: combinational.
// Backpressure: none.
module bcd_digit_adj
    import product_bcd_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= BCD_DIGIT_W'(ADD3_THRESH)) begin
            dout = din + BCD_DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/product_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Latency: out_valid visible IN_W edges after the accept edge; II = IN_W+2.
// Backpressure: holds result in DONE until out_ready; in_ready low outside IDLE.
module product_bcd_seq
    import product_bcd_seq_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [IN_W-1:0]               in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          busy
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int W     = BCD_W + IN_W;
    localparam int CNT_W = $clog2(IN_W + 1);

    if (DIGITS < digits_needed(IN_W)) begin : g_digits_check
        $error("product_bcd_seq: DIGITS too small for IN_W");
    end

    state_t           state, state_nxt;
    logic [W-1:0]     wrk, wrk_nxt, wrk_shift;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [BCD_W-1:0] bcd_q, bcd_nxt;
    logic [BCD_W-1:0] adj;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (wrk[IN_W + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign wrk_shift = {adj, wrk[IN_W-1:0]} << 1;

    // Gated with rst so nothing is offered while reset is held.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign bcd       = bcd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            wrk   <= '0;
            cnt   <= '0;
            bcd_q <= '0;
        end else begin
            state <= state_nxt;
            wrk   <= wrk_nxt;
            cnt   <= cnt_nxt;
            bcd_q <= bcd_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wrk_nxt   = wrk;
        cnt_nxt   = cnt;
        bcd_nxt   = bcd_q;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    wrk_nxt   = {{BCD_W{1'b0}}, in_data};
                    cnt_nxt   = CNT_W'(IN_W);
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                wrk_nxt = wrk_shift;
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    bcd_nxt   = wrk_shift[W-1 -: BCD_W];
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A presented result must never carry a digit above 9.
    always @(posedge clk) begin
        if (!rst && state == DONE) begin
            for (int i = 0; i < DIGITS; i++) begin
                assert (bcd_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] <= BCD_DIGIT_W'(9));
            end
        end
    end

endmodule

// File: tb/tb_product_bcd_seq.sv
// Directed and randomized bench for product_bcd_seq against a decimal reference.
module tb_product_bcd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] bcd;
    logic        busy;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    product_bcd_seq #(.IN_W(8), .DIGITS(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int max_digit(input logic [11:0] b);
        int m;
        m = 0;
        for (int i = 0; i < 3; i++) begin
            if (int'(b[i*4 +: 4]) > m) m = int'(b[i*4 +: 4]);
        end
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Starts at a negedge; returns at the negedge where out_valid is first seen.
    task automatic do_convert(input logic [7:0] v, output int lat, output int acc_cyc);
        int w;
        in_valid = 1'b1;
        in_data  = v;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); @(negedge clk); w++;
        end
        @(posedge clk);
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); @(negedge clk); lat++;
        end
    endtask

    initial begin
        int lat, acc0, acc1, bad, nxt, got, guard;
        logic [7:0] q[$];
        logic [11:0] exp_b;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_bcd", bcd, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        // 225: latency, result, return to IDLE
        do_convert(8'd225, lat, acc0);
        chk("t1_latency", lat, 8);
        chk("t1_bcd", bcd, ref_bcd(225));
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        chk("t1_out_valid_drop", out_valid, 0);
        chk("t1_in_ready_back", in_ready, 1);

        // 0 then 99 back-to-back, out_ready tied high
        out_ready = 1'b1;
        do_convert(8'd0, lat, acc0);
        chk("t2_bcd0", bcd, ref_bcd(0));
        do_convert(8'd99, lat, acc1);
        chk("t2_bcd99", bcd, ref_bcd(99));
        chk("t2_initiation_interval", acc1 - acc0, 10);
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;

        // 255 stalled 5 cycles in DONE
        do_convert(8'd255, lat, acc0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!(out_valid === 1'b1 && bcd === ref_bcd(255))) bad++;
            @(posedge clk); @(negedge clk);
        end
        chk("t3_stall_stable", bad, 0);
        chk("t3_bcd", bcd, ref_bcd(255));
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        chk("t3_exit", out_valid, 0);

        // 144 with stray in_valid pulses carrying 7
        in_valid = 1'b1; in_data = 8'd144;
        @(posedge clk); @(negedge clk);
        bad = 0;
        for (int k = 1; k <= 8; k++) begin
            in_valid = (k == 2 || k == 5);
            in_data  = in_valid ? 8'd7 : 8'd144;
            if (in_ready !== 1'b0) bad++;
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b0;
        chk("t4_in_ready_low", bad, 0);
        chk("t4_out_valid", out_valid, 1);
        chk("t4_bcd", bcd, ref_bcd(144));
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        chk("t4_no_capture", busy, 0);

        // reset during SHIFT on 200
        in_valid = 1'b1; in_data = 8'd200;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        chk("t5_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_bcd", bcd, 0);
        chk("t5_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_convert(8'd36, lat, acc0);
        chk("t5_latency", lat, 8);
        chk("t5_bcd36", bcd, ref_bcd(36));
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);

        // full sweep with random out_ready
        nxt = 0; got = 0; guard = 0;
        while (got < 256 && guard < 20000) begin
            in_valid  = (nxt < 256);
            in_data   = 8'(nxt);
            out_ready = 1'($urandom_range(0, 1));
            if (in_valid && in_ready) begin
                q.push_back(8'(nxt));
                nxt++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("sweep_unexpected_result", 1, 0);
                end else begin
                    exp_b = ref_bcd(int'(q.pop_front()));
                    chk("sweep_bcd", bcd, exp_b);
                    chk("sweep_digit_le9", (max_digit(bcd) <= 9), 1);
                end
                got++;
            end
            @(posedge clk); @(negedge clk);
            guard++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("sweep_count", got, 256);
        chk("sweep_accepted", nxt, 256);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
